// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/forwarding controller with mult/div busy FSM
// Produces forwarding selects, stall/bubble controls and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rt_i,
    input  logic             id_branch_i,
    input  logic             id_md_use_i,
    input  logic             ex_valid_i,
    input  logic             ex_reg_wr_i,
    input  logic             ex_mem_to_reg_i,
    input  logic [4:0]       ex_dst_i,
    input  logic [4:0]       ex_rs_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_md_start_i,
    input  logic             ex_md_div_i,
    input  logic             mem_reg_wr_i,
    input  logic             mem_mem_to_reg_i,
    input  logic [4:0]       mem_dst_i,
    input  logic             wb_reg_wr_i,
    input  logic [4:0]       wb_dst_i,
    input  logic             cnt_clr_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             clr_ex_o,
    output logic [1:0]       fwd_a_ex_o,
    output logic [1:0]       fwd_b_ex_o,
    output logic             fwd_a_id_o,
    output logic             fwd_b_id_o,
    output logic             md_busy_o,
    output logic             md_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MD_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t        state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_done_q, md_done_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use, brn_haz, md_haz, stall;

    // Register 0 is hardwired zero, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        fwd_a_ex_o = 2'b00;
        fwd_b_ex_o = 2'b00;
        if (mem_reg_wr_i && hit(mem_dst_i, ex_rs_i))
            fwd_a_ex_o = 2'b10;
        else if (wb_reg_wr_i && hit(wb_dst_i, ex_rs_i))
            fwd_a_ex_o = 2'b01;
        if (mem_reg_wr_i && hit(mem_dst_i, ex_rt_i))
            fwd_b_ex_o = 2'b10;
        else if (wb_reg_wr_i && hit(wb_dst_i, ex_rt_i))
            fwd_b_ex_o = 2'b01;
    end

    // Load data is not ready in MEM, so only ALU results feed the ID compare.
    assign fwd_a_id_o = mem_reg_wr_i && !mem_mem_to_reg_i && hit(mem_dst_i, id_rs_i);
    assign fwd_b_id_o = mem_reg_wr_i && !mem_mem_to_reg_i && hit(mem_dst_i, id_rt_i);

    assign md_busy_o = (state_q == BUSY);
    assign md_done_o = md_done_q;

    always_comb begin
        load_use = ex_valid_i && ex_mem_to_reg_i &&
                   (hit(ex_dst_i, id_rs_i) || (id_use_rt_i && hit(ex_dst_i, id_rt_i)));
        brn_haz  = id_branch_i &&
                   ((ex_valid_i && ex_reg_wr_i &&
                     (hit(ex_dst_i, id_rs_i) || hit(ex_dst_i, id_rt_i))) ||
                    (mem_mem_to_reg_i &&
                     (hit(mem_dst_i, id_rs_i) || hit(mem_dst_i, id_rt_i))));
        md_haz   = id_md_use_i && (md_busy_o || ex_md_start_i);
        stall    = id_valid_i && (load_use || brn_haz || md_haz);
    end

    assign stall_if_o  = stall;
    assign stall_id_o  = stall;
    assign clr_ex_o    = stall;
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_md_start_i) begin
                    state_d  = BUSY;
                    md_cnt_d = ex_md_div_i ? MD_W'(DIV_LAT - 1) : MD_W'(MUL_LAT - 1);
                end
            end
            BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d   = IDLE;
                    md_done_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q - MD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i)
            stall_cnt_d = '0;
        else if (stall_id_o && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            md_cnt_q    <= '0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk, reset;
    logic       id_valid_i, id_use_rt_i, id_branch_i, id_md_use_i;
    logic [4:0] id_rs_i, id_rt_i;
    logic       ex_valid_i, ex_reg_wr_i, ex_mem_to_reg_i, ex_md_start_i, ex_md_div_i;
    logic [4:0] ex_dst_i, ex_rs_i, ex_rt_i;
    logic       mem_reg_wr_i, mem_mem_to_reg_i, wb_reg_wr_i, cnt_clr_i;
    logic [4:0] mem_dst_i, wb_dst_i;
    logic       stall_if_o, stall_id_o, clr_ex_o, fwd_a_id_o, fwd_b_id_o;
    logic [1:0] fwd_a_ex_o, fwd_b_ex_o;
    logic       md_busy_o, md_done_o;
    logic [3:0] stall_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(12), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_use_rt_i(id_use_rt_i), .id_branch_i(id_branch_i), .id_md_use_i(id_md_use_i),
        .ex_valid_i(ex_valid_i), .ex_reg_wr_i(ex_reg_wr_i), .ex_mem_to_reg_i(ex_mem_to_reg_i),
        .ex_dst_i(ex_dst_i), .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i),
        .ex_md_start_i(ex_md_start_i), .ex_md_div_i(ex_md_div_i),
        .mem_reg_wr_i(mem_reg_wr_i), .mem_mem_to_reg_i(mem_mem_to_reg_i), .mem_dst_i(mem_dst_i),
        .wb_reg_wr_i(wb_reg_wr_i), .wb_dst_i(wb_dst_i), .cnt_clr_i(cnt_clr_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .clr_ex_o(clr_ex_o),
        .fwd_a_ex_o(fwd_a_ex_o), .fwd_b_ex_o(fwd_b_ex_o),
        .fwd_a_id_o(fwd_a_id_o), .fwd_b_id_o(fwd_b_id_o),
        .md_busy_o(md_busy_o), .md_done_o(md_done_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_use_rt_i = 0;
        id_branch_i = 0; id_md_use_i = 0;
        ex_valid_i = 0; ex_reg_wr_i = 0; ex_mem_to_reg_i = 0; ex_dst_i = 0;
        ex_rs_i = 0; ex_rt_i = 0; ex_md_start_i = 0; ex_md_div_i = 0;
        mem_reg_wr_i = 0; mem_mem_to_reg_i = 0; mem_dst_i = 0;
        wb_reg_wr_i = 0; wb_dst_i = 0; cnt_clr_i = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        #1;
        n_cmp++; if (md_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", md_busy_o); end
        n_cmp++; if (md_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", md_done_o); end
        n_cmp++; if (stall_cnt_o !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", stall_cnt_o); end
        n_cmp++; if ({stall_if_o, stall_id_o, clr_ex_o} !== 3'b000) begin n_bad++; $display("FAIL reset_stall got %b want 000", {stall_if_o, stall_id_o, clr_ex_o}); end
        n_cmp++; if ({fwd_a_ex_o, fwd_b_ex_o} !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd got %b want 0000", {fwd_a_ex_o, fwd_b_ex_o}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_alu_fwd();
        mem_reg_wr_i = 1; mem_dst_i = 5; wb_reg_wr_i = 1; wb_dst_i = 5;
        ex_rs_i = 5; ex_rt_i = 5;
        #1;
        n_cmp++; if (fwd_a_ex_o !== 2'b10) begin n_bad++; $display("FAIL fwd_a_mem got %b want 10", fwd_a_ex_o); end
        n_cmp++; if (fwd_b_ex_o !== 2'b10) begin n_bad++; $display("FAIL fwd_b_mem got %b want 10", fwd_b_ex_o); end
        mem_reg_wr_i = 0;
        #1;
        n_cmp++; if (fwd_a_ex_o !== 2'b01) begin n_bad++; $display("FAIL fwd_a_wb got %b want 01", fwd_a_ex_o); end
        ex_rt_i = 6;
        #1;
        n_cmp++; if (fwd_b_ex_o !== 2'b00) begin n_bad++; $display("FAIL fwd_b_none got %b want 00", fwd_b_ex_o); end
        mem_reg_wr_i = 1; mem_dst_i = 6; wb_reg_wr_i = 0;
        #1;
        n_cmp++; if ({fwd_a_ex_o, fwd_b_ex_o} !== 4'b0010) begin n_bad++; $display("FAIL fwd_split got %b want 0010", {fwd_a_ex_o, fwd_b_ex_o}); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_reg0();
        mem_reg_wr_i = 1; mem_dst_i = 0; ex_rs_i = 0; wb_reg_wr_i = 1; wb_dst_i = 0;
        id_valid_i = 1; ex_valid_i = 1; ex_reg_wr_i = 1; ex_mem_to_reg_i = 1;
        ex_dst_i = 0; id_rs_i = 0;
        #1;
        n_cmp++; if (fwd_a_ex_o !== 2'b00) begin n_bad++; $display("FAIL reg0_fwd got %b want 00", fwd_a_ex_o); end
        n_cmp++; if (stall_id_o !== 1'b0) begin n_bad++; $display("FAIL reg0_stall got %b want 0", stall_id_o); end
        n_cmp++; if (fwd_a_id_o !== 1'b0) begin n_bad++; $display("FAIL reg0_fwd_id got %b want 0", fwd_a_id_o); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_load_use();
        id_valid_i = 1; id_rs_i = 7; ex_valid_i = 1; ex_reg_wr_i = 1;
        ex_mem_to_reg_i = 1; ex_dst_i = 7;
        #1;
        n_cmp++; if ({stall_if_o, stall_id_o, clr_ex_o} !== 3'b111) begin n_bad++; $display("FAIL lu_stall got %b want 111", {stall_if_o, stall_id_o, clr_ex_o}); end
        n_cmp++; if (stall_cnt_o !== 4'd0) begin n_bad++; $display("FAIL lu_cnt_before got %0d want 0", stall_cnt_o); end
        id_valid_i = 0;
        #1;
        n_cmp++; if (stall_id_o !== 1'b0) begin n_bad++; $display("FAIL lu_invalid got %b want 0", stall_id_o); end
        id_valid_i = 1; id_rs_i = 1; id_rt_i = 7; id_use_rt_i = 0;
        #1;
        n_cmp++; if (stall_id_o !== 1'b0) begin n_bad++; $display("FAIL lu_rt_unused got %b want 0", stall_id_o); end
        id_use_rt_i = 1;
        #1;
        n_cmp++; if (stall_id_o !== 1'b1) begin n_bad++; $display("FAIL lu_rt_used got %b want 1", stall_id_o); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (stall_id_o !== 1'b0) begin n_bad++; $display("FAIL lu_release got %b want 0", stall_id_o); end
        n_cmp++; if (stall_cnt_o !== 4'd1) begin n_bad++; $display("FAIL lu_cnt_after got %0d want 1", stall_cnt_o); end
        @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 4'd1) begin n_bad++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt_o); end
    endtask

    task automatic test_branch();
        id_valid_i = 1; id_branch_i = 1; id_rs_i = 1; id_rt_i = 3; id_use_rt_i = 0;
        ex_valid_i = 1; ex_reg_wr_i = 1; ex_dst_i = 3;
        #1;
        n_cmp++; if (stall_id_o !== 1'b1) begin n_bad++; $display("FAIL br_ex_stall got %b want 1", stall_id_o); end
        ex_valid_i = 0; ex_reg_wr_i = 0; ex_dst_i = 0;
        mem_reg_wr_i = 1; mem_mem_to_reg_i = 0; mem_dst_i = 3;
        #1;
        n_cmp++; if (stall_id_o !== 1'b0) begin n_bad++; $display("FAIL br_mem_alu_stall got %b want 0", stall_id_o); end
        n_cmp++; if ({fwd_a_id_o, fwd_b_id_o} !== 2'b01) begin n_bad++; $display("FAIL br_fwd_id got %b want 01", {fwd_a_id_o, fwd_b_id_o}); end
        mem_mem_to_reg_i = 1;
        #1;
        n_cmp++; if (fwd_b_id_o !== 1'b0) begin n_bad++; $display("FAIL br_fwd_load got %b want 0", fwd_b_id_o); end
        n_cmp++; if (stall_id_o !== 1'b1) begin n_bad++; $display("FAIL br_mem_load_stall got %b want 1", stall_id_o); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_div();
        ex_md_start_i = 1; ex_md_div_i = 1; id_valid_i = 1; id_md_use_i = 1;
        #1;
        n_cmp++; if (stall_id_o !== 1'b1) begin n_bad++; $display("FAIL md_start_haz got %b want 1", stall_id_o); end
        id_valid_i = 0; id_md_use_i = 0;
        @(negedge clk);
        ex_md_start_i = 0; ex_md_div_i = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_cmp++; if ({md_busy_o, md_done_o} !== 2'b10) begin n_bad++; $display("FAIL div_busy[%0d] got %b want 10", i, {md_busy_o, md_done_o}); end
            if (i == 3) begin
                id_valid_i = 1; id_md_use_i = 1;
                #1;
                n_cmp++; if (stall_id_o !== 1'b1) begin n_bad++; $display("FAIL div_busy_haz got %b want 1", stall_id_o); end
                id_valid_i = 0; id_md_use_i = 0;
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if ({md_busy_o, md_done_o} !== 2'b01) begin n_bad++; $display("FAIL div_done got %b want 01", {md_busy_o, md_done_o}); end
        @(negedge clk);
        n_cmp++; if ({md_busy_o, md_done_o} !== 2'b00) begin n_bad++; $display("FAIL div_after got %b want 00", {md_busy_o, md_done_o}); end
        n_cmp++; if (stall_cnt_o !== 4'd1) begin n_bad++; $display("FAIL div_cnt got %0d want 1", stall_cnt_o); end
    endtask

    task automatic test_back_to_back();
        ex_md_start_i = 1;
        @(negedge clk);
        ex_md_start_i = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({md_busy_o, md_done_o} !== 2'b10) begin n_bad++; $display("FAIL mul1_busy[%0d] got %b want 10", i, {md_busy_o, md_done_o}); end
            @(negedge clk);
        end
        n_cmp++; if ({md_busy_o, md_done_o} !== 2'b01) begin n_bad++; $display("FAIL mul1_done got %b want 01", {md_busy_o, md_done_o}); end
        ex_md_start_i = 1;
        @(negedge clk);
        ex_md_start_i = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({md_busy_o, md_done_o} !== 2'b10) begin n_bad++; $display("FAIL mul2_busy[%0d] got %b want 10", i, {md_busy_o, md_done_o}); end
            @(negedge clk);
        end
        n_cmp++; if ({md_busy_o, md_done_o} !== 2'b01) begin n_bad++; $display("FAIL mul2_done got %b want 01", {md_busy_o, md_done_o}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        ex_md_start_i = 1; ex_md_div_i = 1;
        @(negedge clk);
        ex_md_start_i = 0; ex_md_div_i = 0;
        repeat (4) @(negedge clk);
        n_cmp++; if (md_busy_o !== 1'b1) begin n_bad++; $display("FAIL rm_busy5 got %b want 1", md_busy_o); end
        reset = 0;
        #1;
        n_cmp++; if (md_busy_o !== 1'b0) begin n_bad++; $display("FAIL rm_abort got %b want 0", md_busy_o); end
        n_cmp++; if (stall_cnt_o !== 4'd0) begin n_bad++; $display("FAIL rm_cnt got %0d want 0", stall_cnt_o); end
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (md_done_o !== 1'b0 || md_busy_o !== 1'b0) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rm_no_done got %0d active cycles want 0", dones); end
    endtask

    task automatic test_saturation();
        id_valid_i = 1; id_rs_i = 9; ex_valid_i = 1; ex_mem_to_reg_i = 1; ex_dst_i = 9;
        repeat (10) @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 4'd10) begin n_bad++; $display("FAIL sat_10 got %0d want 10", stall_cnt_o); end
        repeat (5) @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 4'd15) begin n_bad++; $display("FAIL sat_15 got %0d want 15", stall_cnt_o); end
        repeat (5) @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 4'd15) begin n_bad++; $display("FAIL sat_hold got %0d want 15", stall_cnt_o); end
        cnt_clr_i = 1;
        @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 4'd0) begin n_bad++; $display("FAIL sat_clr got %0d want 0", stall_cnt_o); end
        cnt_clr_i = 0;
        @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 4'd1) begin n_bad++; $display("FAIL sat_restart got %0d want 1", stall_cnt_o); end
        idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_reg0();
        test_load_use();
        test_branch();
        test_div();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
